// File: rtl/paddle_line_decoder.sv
// rtl/paddle_line_decoder.sv - scanline-counting paddle position decoder
// Optional macro PADDLE_SMOOTH_EN adds a two-sample averaging output stage.
module paddle_line_decoder #(
    parameter int CNT_W     = 9,
    parameter int MAX_LINES = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             hs,
    input  logic             vs,
    input  logic             pin_in,
    output logic [CNT_W-1:0] pos,
    output logic             pos_valid,
    output logic             timeout,
    output logic             discharge
);

    typedef enum logic [1:0] {IDLE, MEASURE, HOLD} state_t;

    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_LINES);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_LINES - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pin_meta_q, pin_s_q;
    logic             hs_q, vs_q, hs_rise_q, vs_rise_q;
    logic             lat_en;
    logic [CNT_W-1:0] lat_raw;
    logic             lat_to;
    logic [CNT_W-1:0] pos_q;
    logic             pos_valid_q, timeout_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            pin_meta_q <= 1'b0;
            pin_s_q    <= 1'b0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            hs_rise_q  <= 1'b0;
            vs_rise_q  <= 1'b0;
            state_q    <= IDLE;
            cnt_q      <= '0;
        end else begin
            pin_meta_q <= pin_in;
            pin_s_q    <= pin_meta_q;
            hs_q       <= hs;
            vs_q       <= vs;
            hs_rise_q  <= hs & ~hs_q;
            vs_rise_q  <= vs & ~vs_q;
            state_q    <= state_d;
            cnt_q      <= cnt_d;
        end
    end

    // A frame edge always wins over a line edge arriving in the same cycle.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        lat_en  = 1'b0;
        lat_raw = cnt_q;
        lat_to  = 1'b0;
        case (state_q)
            IDLE, HOLD: begin
                if (vs_rise_q) begin
                    cnt_d   = '0;
                    state_d = MEASURE;
                end
            end
            MEASURE: begin
                if (vs_rise_q) begin
                    lat_en = 1'b1;
                    lat_to = 1'b1;
                    cnt_d  = '0;
                end else if (hs_rise_q) begin
                    if (pin_s_q) begin
                        lat_en  = 1'b1;
                        state_d = HOLD;
                    end else if (cnt_q == LAST_CNT) begin
                        lat_en  = 1'b1;
                        lat_raw = MAX_CNT;
                        lat_to  = 1'b1;
                        state_d = HOLD;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

`ifdef PADDLE_SMOOTH_EN
    logic [CNT_W-1:0] raw_q, prev_raw_q;
    logic             raw_to_q, raw_vld_q, seeded_q;
    logic [CNT_W:0]   avg_sum;

    assign avg_sum = {1'b0, raw_q} + {1'b0, prev_raw_q} + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            raw_q       <= '0;
            raw_to_q    <= 1'b0;
            raw_vld_q   <= 1'b0;
            prev_raw_q  <= '0;
            seeded_q    <= 1'b0;
            pos_q       <= '0;
            timeout_q   <= 1'b0;
            pos_valid_q <= 1'b0;
        end else begin
            raw_vld_q   <= lat_en;
            pos_valid_q <= raw_vld_q;
            if (lat_en) begin
                raw_q    <= lat_raw;
                raw_to_q <= lat_to;
            end
            if (raw_vld_q) begin
                pos_q      <= seeded_q ? avg_sum[CNT_W:1] : raw_q;
                timeout_q  <= raw_to_q;
                prev_raw_q <= raw_q;
                seeded_q   <= 1'b1;
            end
        end
    end
`else
    always_ff @(posedge clk) begin
        if (reset) begin
            pos_q       <= '0;
            timeout_q   <= 1'b0;
            pos_valid_q <= 1'b0;
        end else begin
            pos_valid_q <= lat_en;
            if (lat_en) begin
                pos_q     <= lat_raw;
                timeout_q <= lat_to;
            end
        end
    end
`endif

    assign pos       = pos_q;
    assign pos_valid = pos_valid_q;
    assign timeout   = timeout_q;
    assign discharge = vs_q;

endmodule

// File: tb/tb_paddle_line_decoder.sv
// tb/tb_paddle_line_decoder.sv - directed bench for paddle_line_decoder
module tb_paddle_line_decoder;

`ifdef PADDLE_SMOOTH_EN
    localparam int LAT = 3;
`else
    localparam int LAT = 2;
`endif

    logic       clk = 1'b0;
    logic       reset, hs, vs, pin_in;
    logic [8:0] pos;
    logic       pos_valid, timeout, discharge;

    int cyc = 0;
    int strobe_cnt = 0;
    int last_pos = -1;
    int last_to = -1;
    int last_cyc = -1;
    int enc_p = 0;
    int enc_cnt = 0;
    int n_checks = 0;
    int n_fail = 0;

    paddle_line_decoder #(.CNT_W(9), .MAX_LINES(256)) dut (
        .clk(clk), .reset(reset), .hs(hs), .vs(vs), .pin_in(pin_in),
        .pos(pos), .pos_valid(pos_valid), .timeout(timeout), .discharge(discharge)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (pos_valid === 1'b1) begin
            strobe_cnt = strobe_cnt + 1;
            last_pos   = int'(pos);
            last_to    = int'(timeout);
            last_cyc   = cyc;
        end
    end

    // Emulated encoder: pin stays low for enc_p line edges after the frame edge.
    task automatic line(output int hc);
        hs = 1'b1;
        hc = cyc;
        repeat (4) @(negedge clk);
        hs = 1'b0;
        enc_cnt = enc_cnt + 1;
        pin_in = (enc_cnt >= enc_p);
        repeat (4) @(negedge clk);
    endtask

    task automatic frame(output int vc);
        vs = 1'b1;
        vc = cyc;
        enc_cnt = 0;
        pin_in = (enc_p == 0);
        repeat (4) @(negedge clk);
        vs = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b1; hs = 1'b0; vs = 1'b0; pin_in = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (pos !== 9'd0) begin n_fail++; $display("FAIL reset_pos: got %0d expected 0", pos); end
        n_checks++; if (pos_valid !== 1'b0) begin n_fail++; $display("FAIL reset_pos_valid: got %b expected 0", pos_valid); end
        n_checks++; if (timeout !== 1'b0) begin n_fail++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        n_checks++; if (discharge !== 1'b0) begin n_fail++; $display("FAIL reset_discharge: got %b expected 0", discharge); end
        reset = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_discharge;
        vs = 1'b1;
        @(negedge clk);
        n_checks++; if (discharge !== 1'b1) begin n_fail++; $display("FAIL discharge_high: got %b expected 1", discharge); end
        vs = 1'b0;
        @(negedge clk);
        n_checks++; if (discharge !== 1'b0) begin n_fail++; $display("FAIL discharge_low: got %b expected 0", discharge); end
        repeat (4) @(negedge clk);
    endtask

    task automatic test_encoder(input int p);
        int vc, hc, hit, s0;
        hit = -1;
        enc_p = p;
        frame(vc);
        s0 = strobe_cnt;
        for (int i = 0; i < p + 3; i++) begin
            line(hc);
            if (i == p) hit = hc;
        end
        n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL enc%0d_strobes: got %0d expected 1", p, strobe_cnt - s0); end
        n_checks++; if (last_pos !== p) begin n_fail++; $display("FAIL enc%0d_pos: got %0d expected %0d", p, last_pos, p); end
        n_checks++; if (last_to !== 0) begin n_fail++; $display("FAIL enc%0d_timeout: got %0d expected 0", p, last_to); end
        n_checks++; if (last_cyc - hit !== LAT) begin n_fail++; $display("FAIL enc%0d_latency: got %0d expected %0d", p, last_cyc - hit, LAT); end
    endtask

    task automatic test_timeout;
        int vc, hc, hit, s0;
        hit = -1;
        enc_p = 1000;
        frame(vc);
        s0 = strobe_cnt;
        for (int i = 0; i < 300; i++) begin
            line(hc);
            if (i == 255) hit = hc;
        end
        n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL timeout_strobes: got %0d expected 1", strobe_cnt - s0); end
        n_checks++; if (last_pos !== 256) begin n_fail++; $display("FAIL timeout_pos: got %0d expected 256", last_pos); end
        n_checks++; if (last_to !== 1) begin n_fail++; $display("FAIL timeout_flag: got %0d expected 1", last_to); end
        n_checks++; if (last_cyc - hit !== LAT) begin n_fail++; $display("FAIL timeout_latency: got %0d expected %0d", last_cyc - hit, LAT); end
    endtask

    task automatic test_cutoff;
        int vc, hc, s0;
        enc_p = 1000;
        frame(vc);
        for (int i = 0; i < 40; i++) line(hc);
        s0 = strobe_cnt;
        enc_p = 5;
        frame(vc);
        n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL cutoff_strobes: got %0d expected 1", strobe_cnt - s0); end
        n_checks++; if (last_pos !== 40) begin n_fail++; $display("FAIL cutoff_pos: got %0d expected 40", last_pos); end
        n_checks++; if (last_to !== 1) begin n_fail++; $display("FAIL cutoff_flag: got %0d expected 1", last_to); end
        n_checks++; if (last_cyc - vc !== LAT) begin n_fail++; $display("FAIL cutoff_latency: got %0d expected %0d", last_cyc - vc, LAT); end
        for (int i = 0; i < 8; i++) line(hc);
        n_checks++; if (strobe_cnt - s0 !== 2) begin n_fail++; $display("FAIL cutoff_next_strobes: got %0d expected 2", strobe_cnt - s0); end
        n_checks++; if (last_pos !== 5 || last_to !== 0) begin n_fail++; $display("FAIL cutoff_next_pos: got %0d/%0d expected 5/0", last_pos, last_to); end
    endtask

    task automatic test_same_edge;
        int vc, hc, s0;
        enc_p = 1000;
        frame(vc);
        for (int i = 0; i < 20; i++) line(hc);
        s0 = strobe_cnt;
        enc_p = 3;
        vs = 1'b1; hs = 1'b1; enc_cnt = 0; pin_in = 1'b0;
        repeat (4) @(negedge clk);
        vs = 1'b0; hs = 1'b0;
        repeat (4) @(negedge clk);
        n_checks++; if (last_pos !== 20 || last_to !== 1) begin n_fail++; $display("FAIL same_edge_pos: got %0d/%0d expected 20/1", last_pos, last_to); end
        for (int i = 0; i < 6; i++) line(hc);
        n_checks++; if (strobe_cnt - s0 !== 2) begin n_fail++; $display("FAIL same_edge_strobes: got %0d expected 2", strobe_cnt - s0); end
        n_checks++; if (last_pos !== 3 || last_to !== 0) begin n_fail++; $display("FAIL same_edge_next_pos: got %0d/%0d expected 3/0", last_pos, last_to); end
    endtask

    task automatic test_reset_mid;
        int vc, hc, s0;
        enc_p = 1000;
        frame(vc);
        for (int i = 0; i < 50; i++) line(hc);
        s0 = strobe_cnt;
        reset = 1'b1;
        @(negedge clk);
        n_checks++; if (pos !== 9'd0) begin n_fail++; $display("FAIL rstmid_pos: got %0d expected 0", pos); end
        n_checks++; if (pos_valid !== 1'b0 || timeout !== 1'b0 || discharge !== 1'b0) begin n_fail++; $display("FAIL rstmid_flags: got %b%b%b expected 000", pos_valid, timeout, discharge); end
        @(negedge clk);
        reset = 1'b0;
        for (int i = 0; i < 10; i++) line(hc);
        n_checks++; if (strobe_cnt !== s0) begin n_fail++; $display("FAIL rstmid_idle_strobes: got %0d expected %0d", strobe_cnt, s0); end
        enc_p = 7;
        frame(vc);
        for (int i = 0; i < 10; i++) line(hc);
        n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL rstmid_strobes: got %0d expected 1", strobe_cnt - s0); end
        n_checks++; if (last_pos !== 7 || last_to !== 0) begin n_fail++; $display("FAIL rstmid_pos_after: got %0d/%0d expected 7/0", last_pos, last_to); end
    endtask

    task automatic test_smooth;
        int vc, hc, s0;
        int seq [4];
        int expv [4];
        seq = '{100, 200, 201, 201};
`ifdef PADDLE_SMOOTH_EN
        expv = '{100, 150, 201, 201};
`else
        expv = '{100, 200, 201, 201};
`endif
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        for (int f = 0; f < 4; f++) begin
            enc_p = seq[f];
            frame(vc);
            s0 = strobe_cnt;
            for (int i = 0; i < seq[f] + 3; i++) line(hc);
            n_checks++; if (strobe_cnt - s0 !== 1) begin n_fail++; $display("FAIL smooth%0d_strobes: got %0d expected 1", f, strobe_cnt - s0); end
            n_checks++; if (last_pos !== expv[f] || last_to !== 0) begin n_fail++; $display("FAIL smooth%0d_pos: got %0d/%0d expected %0d/0", f, last_pos, last_to, expv[f]); end
        end
    endtask

    initial begin
        @(negedge clk);
        test_reset();
        test_discharge();
        test_encoder(0);
        test_encoder(1);
        test_encoder(128);
        test_timeout();
        test_cutoff();
        test_same_edge();
        test_reset_mid();
        test_smooth();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
